// File: rtl/dma_pkg.sv
// Shared constants, state type and byte-merge helper for the DMA copy engine.
package dma_pkg;

   // Responder register indices (mem_addr[3:2])
   localparam logic [1:0] REG_SRC = 2'd0;
   localparam logic [1:0] REG_DST = 2'd1;
   localparam logic [1:0] REG_LEN = 2'd2;
   localparam logic [1:0] REG_CTL = 2'd3;

   // CTRL write bits
   localparam int CTL_START = 0;
   localparam int CTL_ABORT = 1;
   localparam int CTL_CLEAR = 2;

   // STAT read bits
   localparam int STAT_BUSY    = 0;
   localparam int STAT_DONE    = 1;
   localparam int STAT_ERR     = 2;
   localparam int STAT_ABORTED = 3;

   // Master byte strobes: all-zero is a read, all-one a full-word write
   localparam logic [3:0] STRB_READ  = 4'b0000;
   localparam logic [3:0] STRB_WRITE = 4'b1111;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_RGAP,
      ST_WRITE,
      ST_WGAP
   } dma_state_e;

   // Replace the bytes of old_val selected by be with the matching bytes of new_val
   function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
      logic [31:0] merged;
      for (int i = 0; i < 4; i++) begin
         merged[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/dma_regs.sv
// CPU-facing register file: SRC/DST/LEN with byte strobes, sticky status, read mux.
module dma_regs
   import dma_pkg::*;
#(
   parameter int LEN_W  = 16,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [3:0]        s_wen,
   input  logic [1:0]        s_addr,
   input  logic [31:0]       s_wdata,
   output logic [31:0]       s_rdata,
   input  logic              busy,
   input  logic              len_dec,
   input  logic              set_done,
   input  logic              set_err,
   input  logic              set_abort,
   output logic [ADDR_W-1:0] src,
   output logic [ADDR_W-1:0] dst,
   output logic [LEN_W-1:0]  len,
   output logic              start_req,
   output logic              abort_req
);

   logic ctl_wr;
   logic clear_req;
   logic status_clr;
   logic done_q;
   logic err_q;
   logic aborted_q;

   assign ctl_wr    = (s_addr == REG_CTL) && s_wen[0];
   assign start_req = ctl_wr && s_wdata[CTL_START];
   assign abort_req = ctl_wr && s_wdata[CTL_ABORT];
   assign clear_req = ctl_wr && s_wdata[CTL_CLEAR];
   // An accepted start also wipes the previous outcome; start while busy does not
   assign status_clr = clear_req || (start_req && !busy);

   // Programmed registers: CPU writes only while idle, LEN counts down during a job
   always_ff @(posedge clk) begin
      // NOTE: every register here is updated with <= so all flops see pre-edge values
      if (!resetn) begin
         src <= '0;
         dst <= '0;
         len <= '0;
      end else if (!busy) begin
         if (s_addr == REG_SRC && s_wen != 4'b0000)
            src <= ADDR_W'(byte_merge(32'(src), s_wdata, s_wen));
         if (s_addr == REG_DST && s_wen != 4'b0000)
            dst <= ADDR_W'(byte_merge(32'(dst), s_wdata, s_wen));
         if (s_addr == REG_LEN && s_wen != 4'b0000)
            len <= LEN_W'(byte_merge(32'(len), s_wdata, s_wen));
      end else if (len_dec) begin
         len <= len - LEN_W'(1);
      end
   end

   // Sticky outcome bits: a set from the engine wins over a same-cycle clear
   always_ff @(posedge clk) begin
      if (!resetn) begin
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         if (set_done)        done_q <= 1'b1;
         else if (status_clr) done_q <= 1'b0;
         if (set_err)         err_q <= 1'b1;
         else if (status_clr) err_q <= 1'b0;
         if (set_abort)       aborted_q <= 1'b1;
         else if (status_clr) aborted_q <= 1'b0;
      end
   end

   // Combinational read mux
   always_comb begin
      // NOTE: defaulting the output first keeps every path assigned, so no latch
      s_rdata = '0;
      case (s_addr)
         REG_SRC: s_rdata = 32'(src);
         REG_DST: s_rdata = 32'(dst);
         REG_LEN: s_rdata = 32'(len);
         REG_CTL: begin
            s_rdata[STAT_BUSY]    = busy;
            s_rdata[STAT_DONE]    = done_q;
            s_rdata[STAT_ERR]     = err_q;
            s_rdata[STAT_ABORTED] = aborted_q;
         end
         default: s_rdata = '0;
      endcase
   end

endmodule

// File: rtl/dma_copy_master.sv
// Word-granular memory-to-memory copy engine: read a word, write it, repeat.
module dma_copy_master
   import dma_pkg::*;
#(
   parameter int LEN_W  = 16,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [3:0]        s_wen,
   input  logic [1:0]        s_addr,
   input  logic [31:0]       s_wdata,
   output logic [31:0]       s_rdata,
   output logic              m_valid,
   output logic [ADDR_W-1:0] m_addr,
   output logic [31:0]       m_wdata,
   output logic [3:0]        m_wstrb,
   input  logic [31:0]       m_rdata,
   input  logic              m_ready,
   output logic              irq_done
);

   dma_state_e        state_q;
   dma_state_e        state_d;
   logic [ADDR_W-1:0] src_reg;
   logic [ADDR_W-1:0] dst_reg;
   logic [LEN_W-1:0]  len_reg;
   logic [ADDR_W-1:0] src_ptr;
   logic [ADDR_W-1:0] dst_ptr;
   logic [31:0]       word_buf;
   logic              abort_pend;
   logic              abort_now;
   logic              start_req;
   logic              abort_req;
   logic              busy;
   logic              misaligned;
   logic              last_word;
   logic              load_ptrs;
   logic              adv_ptrs;
   logic              latch_buf;
   logic              len_dec;
   logic              set_done;
   logic              set_err;
   logic              set_abort;
   logic              irq_d;

   assign busy       = (state_q != ST_IDLE);
   assign misaligned = (src_reg[1:0] != 2'b00) || (dst_reg[1:0] != 2'b00);
   assign last_word  = (len_reg == LEN_W'(1));
   // An abort written in the very cycle a transfer completes still counts
   assign abort_now  = abort_pend || abort_req;

   dma_regs #(
      .LEN_W  (LEN_W),
      .ADDR_W (ADDR_W)
   ) u_regs (
      .clk       (clk),
      .resetn    (resetn),
      .s_wen     (s_wen),
      .s_addr    (s_addr),
      .s_wdata   (s_wdata),
      .s_rdata   (s_rdata),
      .busy      (busy),
      .len_dec   (len_dec),
      .set_done  (set_done),
      .set_err   (set_err),
      .set_abort (set_abort),
      .src       (src_reg),
      .dst       (dst_reg),
      .len       (len_reg),
      .start_req (start_req),
      .abort_req (abort_req)
   );

   // State register
   always_ff @(posedge clk) begin
      if (!resetn) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   // Next state, bus outputs and datapath controls; bus outputs depend only on
   // state and stable registers, so they hold steady through wait states
   always_comb begin
      state_d   = state_q;
      m_valid   = 1'b0;
      m_addr    = '0;
      m_wdata   = '0;
      m_wstrb   = STRB_READ;
      load_ptrs = 1'b0;
      adv_ptrs  = 1'b0;
      latch_buf = 1'b0;
      len_dec   = 1'b0;
      set_done  = 1'b0;
      set_err   = 1'b0;
      set_abort = 1'b0;
      irq_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_req) begin
               if (misaligned) begin
                  set_err = 1'b1;
                  irq_d   = 1'b1;
               end else if (len_reg == '0) begin
                  set_done = 1'b1;
                  irq_d    = 1'b1;
               end else begin
                  load_ptrs = 1'b1;
                  state_d   = ST_READ;
               end
            end
         end
         ST_READ: begin
            m_valid = 1'b1;
            m_addr  = src_ptr;
            m_wstrb = STRB_READ;
            if (m_ready) begin
               latch_buf = 1'b1;
               if (abort_now) begin
                  set_abort = 1'b1;
                  irq_d     = 1'b1;
                  state_d   = ST_IDLE;
               end else begin
                  state_d = ST_WGAP;
               end
            end
         end
         ST_WGAP: state_d = ST_WRITE;
         ST_WRITE: begin
            m_valid = 1'b1;
            m_addr  = dst_ptr;
            m_wdata = word_buf;
            m_wstrb = STRB_WRITE;
            if (m_ready) begin
               adv_ptrs = 1'b1;
               len_dec  = 1'b1;
               // Finishing the last word reports done even if an abort is pending
               if (last_word) begin
                  set_done = 1'b1;
                  irq_d    = 1'b1;
                  state_d  = ST_IDLE;
               end else if (abort_now) begin
                  set_abort = 1'b1;
                  irq_d     = 1'b1;
                  state_d   = ST_IDLE;
               end else begin
                  state_d = ST_RGAP;
               end
            end
         end
         ST_RGAP: state_d = ST_READ;
         default: state_d = ST_IDLE;
      endcase
   end

   // Working pointers, word buffer, abort-pending flag and the completion pulse
   always_ff @(posedge clk) begin
      if (!resetn) begin
         src_ptr    <= '0;
         dst_ptr    <= '0;
         word_buf   <= '0;
         abort_pend <= 1'b0;
         irq_done   <= 1'b0;
      end else begin
         irq_done <= irq_d;
         if (load_ptrs) begin
            src_ptr <= src_reg;
            dst_ptr <= dst_reg;
         end else if (adv_ptrs) begin
            src_ptr <= src_ptr + ADDR_W'(4);
            dst_ptr <= dst_ptr + ADDR_W'(4);
         end
         if (latch_buf) word_buf <= m_rdata;
         if (state_d == ST_IDLE)     abort_pend <= 1'b0;
         else if (abort_req && busy) abort_pend <= 1'b1;
      end
   end

endmodule

// File: tb/tb_dma_copy_master.sv
// Self-checking bench for dma_copy_master with a wait-state-capable memory responder.
module tb_dma_copy_master;
   import dma_pkg::*;

   typedef struct packed {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
   } txn_t;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [3:0]  s_wen = 4'h0;
   logic [1:0]  s_addr = 2'd0;
   logic [31:0] s_wdata = 32'h0;
   logic [31:0] s_rdata;
   logic        m_valid;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [3:0]  m_wstrb;
   logic [31:0] m_rdata = 32'h0;
   logic        m_ready = 1'b0;
   logic        irq_done;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] mem [0:1023];
   int   wait_cfg = 0;
   int   wcnt = 0;
   txn_t log_q [$];
   bit   vtrace [$];
   int   irq_count;
   int   extra_valid;

   dma_copy_master dut (
      .clk      (clk),
      .resetn   (resetn),
      .s_wen    (s_wen),
      .s_addr   (s_addr),
      .s_wdata  (s_wdata),
      .s_rdata  (s_rdata),
      .m_valid  (m_valid),
      .m_addr   (m_addr),
      .m_wdata  (m_wdata),
      .m_wstrb  (m_wstrb),
      .m_rdata  (m_rdata),
      .m_ready  (m_ready),
      .irq_done (irq_done)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Memory responder: answers after wait_cfg wait cycles, logs every completed access
   always @(negedge clk) begin
      m_ready = 1'b0;
      m_rdata = $urandom;
      if (m_valid) begin
         if (wcnt >= wait_cfg) begin
            m_ready = 1'b1;
            if (m_wstrb == 4'h0) begin
               m_rdata = mem[m_addr[11:2]];
               log_q.push_back(txn_t'{wr: 1'b0, addr: m_addr, data: m_rdata});
            end else begin
               log_q.push_back(txn_t'{wr: 1'b1, addr: m_addr, data: m_wdata});
            end
            wcnt = 0;
         end else begin
            wcnt = wcnt + 1;
         end
      end else begin
         wcnt = 0;
      end
   end

   task automatic reg_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
      @(negedge clk);
      s_addr  = a;
      s_wdata = d;
      s_wen   = be;
      @(posedge clk);
      #1;
      s_wen = 4'h0;
   endtask

   task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
      s_addr = a;
      #1;
      d = s_rdata;
   endtask

   // Expected m_valid level k cycles after start for wait w: (w+1) high, 1 low, (w+1) high, 1 low
   function automatic bit exp_valid(input int k, input int w);
      int p;
      int pos;
      p   = 2 * w + 4;
      pos = k % p;
      return !(pos == w + 1 || pos == p - 1);
   endfunction

   // Follow a job until irq_done, optionally writing abort at the start of the Nth write;
   // also checks that the request stays stable while the responder waits
   task automatic run_job(input int abort_nth_write);
      int   writes_seen = 0;
      bit   prev_v = 1'b0;
      bit   done_seen = 1'b0;
      logic [31:0] h_addr = '0;
      logic [31:0] h_wdata = '0;
      logic [3:0]  h_strb = '0;
      vtrace.delete();
      irq_count   = 0;
      extra_valid = 0;
      for (int c = 0; c < 2000 && !done_seen; c++) begin
         @(negedge clk);
         if (s_wen != 4'h0) s_wen = 4'h0;
         vtrace.push_back(m_valid);
         if (irq_done) begin
            irq_count++;
            done_seen = 1'b1;
         end
         if (m_valid && prev_v) begin
            n_checks++;
            if (m_addr !== h_addr || m_wdata !== h_wdata || m_wstrb !== h_strb) begin
               n_fail++;
               $display("FAIL bus_stable: got %h/%h/%h held %h/%h/%h", m_addr, m_wdata, m_wstrb,
                        h_addr, h_wdata, h_strb);
            end
         end
         if (m_valid && !prev_v) begin
            h_addr  = m_addr;
            h_wdata = m_wdata;
            h_strb  = m_wstrb;
            if (m_wstrb == 4'hF) begin
               writes_seen++;
               if (writes_seen == abort_nth_write) begin
                  s_addr  = REG_CTL;
                  s_wdata = 32'h2;
                  s_wen   = 4'h1;
               end
            end
         end
         prev_v = m_valid;
      end
      n_checks++;
      if (!done_seen) begin
         n_fail++;
         $display("FAIL job_timeout: irq_done not seen within 2000 cycles");
      end
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (irq_done) irq_count++;
         if (m_valid) extra_valid++;
      end
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({m_valid, m_addr, m_wdata, m_wstrb, irq_done} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got v=%b a=%h d=%h s=%h irq=%b want all 0",
                  m_valid, m_addr, m_wdata, m_wstrb, irq_done);
      end
      for (int r = 0; r < 4; r++) begin
         read_reg(2'(r), rd);
         n_checks++;
         if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_reg%0d: got %h want 0", r, rd);
         end
      end
      resetn = 1'b1;
   endtask

   task automatic test_copy(input logic [31:0] src, input logic [31:0] dst, input int n, input int w);
      logic [31:0] words [0:15];
      logic [31:0] rd;
      txn_t exp;
      int   base;
      int   bad;
      int   got_n;
      wait_cfg = w;
      for (int i = 0; i < n; i++) begin
         words[i] = $urandom;
         mem[int'(src >> 2) + i] = words[i];
      end
      reg_write(REG_SRC, src, 4'hF);
      reg_write(REG_DST, dst, 4'hF);
      reg_write(REG_LEN, 32'(n), 4'hF);
      base = log_q.size();
      reg_write(REG_CTL, 32'h1, 4'hF);
      run_job(0);

      n_checks++;
      if (vtrace.size() != n * (2 * w + 4)) begin
         n_fail++;
         $display("FAIL job_cycles: got %0d want %0d", vtrace.size(), n * (2 * w + 4));
      end
      bad = 0;
      for (int k = 0; k < vtrace.size(); k++) if (vtrace[k] != exp_valid(k, w)) bad++;
      n_checks++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL valid_pattern: got %0d wrong cycles want 0", bad);
      end
      got_n = log_q.size() - base;
      n_checks++;
      if (got_n != 2 * n) begin
         n_fail++;
         $display("FAIL txn_count: got %0d want %0d", got_n, 2 * n);
      end
      for (int i = 0; i < 2 * n && i < got_n; i++) begin
         exp.wr   = 1'(i % 2);
         exp.addr = ((i % 2) != 0 ? dst : src) + 32'(4 * (i / 2));
         exp.data = words[i / 2];
         n_checks++;
         if (log_q[base + i] !== exp) begin
            n_fail++;
            $display("FAIL txn%0d: got %b/%h/%h want %b/%h/%h", i, log_q[base + i].wr,
                     log_q[base + i].addr, log_q[base + i].data, exp.wr, exp.addr, exp.data);
         end
      end
      n_checks++;
      if (irq_count != 1 || extra_valid != 0) begin
         n_fail++;
         $display("FAIL irq_once: got irq=%0d extra_valid=%0d want 1/0", irq_count, extra_valid);
      end
      read_reg(REG_CTL, rd);
      n_checks++;
      if (rd !== 32'h2) begin
         n_fail++;
         $display("FAIL stat_done: got %h want 00000002", rd);
      end
      read_reg(REG_LEN, rd);
      n_checks++;
      if (rd !== 32'h0) begin
         n_fail++;
         $display("FAIL len_end: got %h want 0", rd);
      end
      read_reg(REG_SRC, rd);
      n_checks++;
      if (rd !== src) begin
         n_fail++;
         $display("FAIL src_kept: got %h want %h", rd, src);
      end
   endtask

   task automatic test_abort();
      logic [31:0] words [0:4];
      logic [31:0] rd;
      txn_t exp;
      int   base;
      int   got_n;
      wait_cfg = 3;
      for (int i = 0; i < 5; i++) begin
         words[i] = $urandom;
         mem[(32'h100 >> 2) + i] = words[i];
      end
      reg_write(REG_SRC, 32'h100, 4'hF);
      reg_write(REG_DST, 32'h200, 4'hF);
      reg_write(REG_LEN, 32'd5, 4'hF);
      base = log_q.size();
      reg_write(REG_CTL, 32'h1, 4'hF);
      run_job(2);
      got_n = log_q.size() - base;
      n_checks++;
      if (got_n != 4) begin
         n_fail++;
         $display("FAIL abort_txn_count: got %0d want 4", got_n);
      end
      for (int i = 0; i < 4 && i < got_n; i++) begin
         exp.wr   = 1'(i % 2);
         exp.addr = ((i % 2) != 0 ? 32'h200 : 32'h100) + 32'(4 * (i / 2));
         exp.data = words[i / 2];
         n_checks++;
         if (log_q[base + i] !== exp) begin
            n_fail++;
            $display("FAIL abort_txn%0d: got %h/%h want %h/%h", i, log_q[base + i].addr,
                     log_q[base + i].data, exp.addr, exp.data);
         end
      end
      read_reg(REG_CTL, rd);
      n_checks++;
      if (rd !== 32'h8) begin
         n_fail++;
         $display("FAIL abort_stat: got %h want 00000008", rd);
      end
      read_reg(REG_LEN, rd);
      n_checks++;
      if (rd !== 32'd3) begin
         n_fail++;
         $display("FAIL abort_len: got %h want 3", rd);
      end
      n_checks++;
      if (irq_count != 1 || extra_valid != 0) begin
         n_fail++;
         $display("FAIL abort_irq: got irq=%0d extra_valid=%0d want 1/0", irq_count, extra_valid);
      end
   endtask

   task automatic test_no_traffic(input logic [31:0] src, input logic [31:0] dst,
                                  input logic [31:0] len, input logic [31:0] exp_stat);
      logic [31:0] rd;
      int   base;
      int   irqs = 0;
      int   vcnt = 0;
      reg_write(REG_SRC, src, 4'hF);
      reg_write(REG_DST, dst, 4'hF);
      reg_write(REG_LEN, len, 4'hF);
      base = log_q.size();
      reg_write(REG_CTL, 32'h1, 4'hF);
      @(negedge clk);
      read_reg(REG_CTL, rd);
      n_checks++;
      if (rd !== exp_stat || irq_done !== 1'b1) begin
         n_fail++;
         $display("FAIL quick_end src=%h len=%0d: got stat=%h irq=%b want %h/1", src, len, rd,
                  irq_done, exp_stat);
      end
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (irq_done) irqs++;
         if (m_valid) vcnt++;
      end
      n_checks++;
      if (irqs != 0 || vcnt != 0 || log_q.size() != base) begin
         n_fail++;
         $display("FAIL quick_quiet src=%h: got irq=%0d valid=%0d txns=%0d want 0/0/0", src, irqs,
                  vcnt, log_q.size() - base);
      end
   endtask

   task automatic test_clear_while_busy();
      logic [31:0] rd;
      logic [31:0] words [0:1];
      int   base;
      int   got_n;
      reg_write(REG_CTL, 32'h4, 4'hF);
      read_reg(REG_CTL, rd);
      n_checks++;
      if (rd !== 32'h0) begin
         n_fail++;
         $display("FAIL clear_stat: got %h want 0", rd);
      end
      wait_cfg = 2;
      for (int i = 0; i < 2; i++) begin
         words[i] = $urandom;
         mem[(32'h100 >> 2) + i] = words[i];
      end
      reg_write(REG_SRC, 32'h100, 4'hF);
      reg_write(REG_DST, 32'h200, 4'hF);
      reg_write(REG_LEN, 32'd2, 4'hF);
      read_reg(REG_SRC, rd);
      n_checks++;
      if (rd !== 32'h100) begin
         n_fail++;
         $display("FAIL clear_kept_src: got %h want 00000100", rd);
      end
      base = log_q.size();
      reg_write(REG_CTL, 32'h1, 4'hF);
      reg_write(REG_CTL, 32'h1, 4'hF);
      reg_write(REG_SRC, 32'h300, 4'hF);
      read_reg(REG_SRC, rd);
      n_checks++;
      if (rd !== 32'h100) begin
         n_fail++;
         $display("FAIL busy_src_write: got %h want 00000100", rd);
      end
      read_reg(REG_CTL, rd);
      n_checks++;
      if (rd !== 32'h1) begin
         n_fail++;
         $display("FAIL busy_stat: got %h want 00000001", rd);
      end
      run_job(0);
      got_n = log_q.size() - base;
      n_checks++;
      if (got_n != 4) begin
         n_fail++;
         $display("FAIL busy_txn_count: got %0d want 4", got_n);
      end else begin
         n_checks++;
         if (log_q[base + 2].addr !== 32'h104 || log_q[base + 3].addr !== 32'h204 ||
             log_q[base + 3].data !== words[1]) begin
            n_fail++;
            $display("FAIL busy_txn: got %h %h=%h want 00000104 00000204=%h",
                     log_q[base + 2].addr, log_q[base + 3].addr, log_q[base + 3].data, words[1]);
         end
      end
      read_reg(REG_CTL, rd);
      n_checks++;
      if (rd !== 32'h2) begin
         n_fail++;
         $display("FAIL busy_end_stat: got %h want 00000002", rd);
      end
   endtask

   task automatic test_random(input int jobs);
      for (int j = 0; j < jobs; j++) begin
         test_copy(32'($urandom_range(0, 63)) << 2, 32'h400 + (32'($urandom_range(0, 63)) << 2),
                   int'($urandom_range(1, 6)), int'($urandom_range(0, 2)));
      end
   endtask

   task automatic test_reset_mid_read();
      logic [31:0] rd;
      int base;
      wait_cfg = 6;
      reg_write(REG_SRC, 32'h100, 4'hF);
      reg_write(REG_DST, 32'h200, 4'hF);
      reg_write(REG_LEN, 32'd2, 4'hF);
      base = log_q.size();
      reg_write(REG_CTL, 32'h1, 4'hF);
      @(negedge clk);
      n_checks++;
      if (m_valid !== 1'b1 || m_wstrb !== 4'h0) begin
         n_fail++;
         $display("FAIL mid_read_active: got v=%b s=%h want 1/0", m_valid, m_wstrb);
      end
      resetn = 1'b0;
      @(negedge clk);
      n_checks++;
      if (m_valid !== 1'b0 || irq_done !== 1'b0 || m_addr !== 32'h0) begin
         n_fail++;
         $display("FAIL mid_read_reset: got v=%b irq=%b a=%h want 0/0/0", m_valid, irq_done, m_addr);
      end
      for (int r = 0; r < 4; r++) begin
         read_reg(2'(r), rd);
         n_checks++;
         if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_read_reg%0d: got %h want 0", r, rd);
         end
      end
      resetn = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if (log_q.size() != base || m_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_read_quiet: got txns=%0d v=%b want 0/0", log_q.size() - base, m_valid);
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      test_reset();
      test_copy(32'h100, 32'h200, 3, 0);
      test_copy(32'h100, 32'h200, 3, 3);
      test_abort();
      test_no_traffic(32'h102, 32'h200, 32'd3, 32'h4);
      test_no_traffic(32'h100, 32'h201, 32'd3, 32'h4);
      test_no_traffic(32'h100, 32'h200, 32'd0, 32'h2);
      test_clear_while_busy();
      test_random(4);
      test_reset_mid_read();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
